// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: ALU operator codes,
// command encodings and sequencer FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01
    } alu_op_e;

    typedef enum logic [1:0] {
        CMD_ADD = 2'b00,
        CMD_SUB = 2'b01,
        CMD_MUL = 2'b10,
        CMD_ILL = 2'b11
    } seq_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Drives an external ALU for ADD/SUB (one pass) and MUL (shift-add loop).
// Define ALU_SEQ_EARLY_EXIT_EN to stop MUL once the remaining multiplier is zero.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int SIZE = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [SIZE:0]   req_a_i,
    input  logic [SIZE:0]   req_b_i,
    output logic [1:0]      alu_operator_o,
    output logic [SIZE:0]   alu_operand_a_o,
    output logic [SIZE:0]   alu_operand_b_o,
    input  logic [SIZE:0]   alu_result_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [SIZE:0]   rsp_result_o,
    output logic            rsp_err_o
);

    localparam int CW = $clog2(SIZE + 2);
    localparam logic [CW-1:0] LAST_STEP = CW'(SIZE);

    seq_state_e     state, state_n;
    seq_cmd_e       op_q, op_n;
    logic [SIZE:0]  a_q, a_n, b_q, b_n;
    logic [SIZE:0]  acc, acc_n, mcand, mcand_n, mplier, mplier_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           req_ready, req_ready_n;
    logic           rsp_valid, rsp_valid_n;
    logic [SIZE:0]  rsp_result, rsp_result_n;
    logic           rsp_err, rsp_err_n;
    alu_op_e        alu_op;
    logic [SIZE:0]  opnd_a, opnd_b;

    logic [SIZE:0]  acc_step, mplier_sh;
    logic           mul_last;

    assign acc_step  = mplier[0] ? alu_result_i : acc;
    assign mplier_sh = mplier >> 1;

`ifdef ALU_SEQ_EARLY_EXIT_EN
    assign mul_last = (cnt == LAST_STEP) || (mplier_sh == '0);
`else
    assign mul_last = (cnt == LAST_STEP);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            op_q       <= CMD_ADD;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            a_q        <= a_n;
            b_q        <= b_n;
            acc        <= acc_n;
            mcand      <= mcand_n;
            mplier     <= mplier_n;
            cnt        <= cnt_n;
            req_ready  <= req_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_result <= rsp_result_n;
            rsp_err    <= rsp_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        op_n         = op_q;
        a_n          = a_q;
        b_n          = b_q;
        acc_n        = acc;
        mcand_n      = mcand;
        mplier_n     = mplier;
        cnt_n        = cnt;
        rsp_valid_n  = rsp_valid;
        rsp_result_n = rsp_result;
        rsp_err_n    = rsp_err;
        alu_op       = ALU_ADD;
        opnd_a       = '0;
        opnd_b       = '0;

        case (state)
            IDLE: begin
                if (req_valid_i && req_ready) begin
                    op_n = seq_cmd_e'(req_op_i);
                    a_n  = req_a_i;
                    b_n  = req_b_i;
                    case (seq_cmd_e'(req_op_i))
                        CMD_ADD, CMD_SUB: state_n = EXEC;
                        CMD_MUL: begin
                            acc_n    = '0;
                            mcand_n  = req_a_i;
                            mplier_n = req_b_i;
                            cnt_n    = '0;
                            state_n  = MUL;
                        end
                        default: begin
                            rsp_result_n = '0;
                            rsp_err_n    = 1'b1;
                            rsp_valid_n  = 1'b1;
                            state_n      = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                alu_op       = (op_q == CMD_SUB) ? ALU_SUB : ALU_ADD;
                opnd_a       = a_q;
                opnd_b       = b_q;
                rsp_result_n = alu_result_i;
                rsp_valid_n  = 1'b1;
                state_n      = DONE;
            end
            MUL: begin
                // ALU always computes acc+mcand; the sum is kept only when the multiplier bit is set
                opnd_a   = acc;
                opnd_b   = mcand;
                acc_n    = acc_step;
                mcand_n  = mcand << 1;
                mplier_n = mplier_sh;
                cnt_n    = cnt + CW'(1);
                if (mul_last) begin
                    rsp_result_n = acc_step;
                    rsp_valid_n  = 1'b1;
                    state_n      = DONE;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    rsp_valid_n = 1'b0;
                    rsp_err_n   = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        req_ready_n = (state_n == IDLE);
    end

    assign req_ready_o     = req_ready;
    assign rsp_valid_o     = rsp_valid;
    assign rsp_result_o    = rsp_result;
    assign rsp_err_o       = rsp_err;
    assign alu_operator_o  = alu_op;
    assign alu_operand_a_o = opnd_a;
    assign alu_operand_b_o = opnd_b;

endmodule
